// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter with a send/busy handshake.
// Pops one byte at a time, strobes tx_send, then tracks uart_busy rise/fall (with rise timeout).
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH     = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       ovf_clr,
  input  logic                       uart_busy,
  output logic [7:0]                 tx_data,
  output logic                       tx_send,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RISE = 2'd2,
    WAIT_FALL = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] wait_cnt;
  logic [7:0]    mem [DEPTH];

  logic push;
  logic pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign idle  = empty && (state == IDLE);

  // Full check uses pre-edge count, so a pop in the same cycle cannot make room.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !uart_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_data  <= 8'h00;
      tx_send  <= 1'b0;
      overflow <= 1'b0;
      wait_cnt <= '0;
    end else begin
      tx_send <= 1'b0;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A dropped write takes priority over a clear in the same cycle.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + AW'(1);
            tx_send <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          wait_cnt <= '0;
          state    <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (uart_busy) begin
            state <= WAIT_FALL;
          end else if (wait_cnt == WW'(BUSY_WAIT - 1)) begin
            // Transmitter never acknowledged; the byte is dropped rather than retried.
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        WAIT_FALL: begin
          if (!uart_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven and sequence checks for uart_tx_fifo.
`default_nettype none

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       uart_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       idle;

  uart_tx_fifo #(.DEPTH(8), .BUSY_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .uart_busy (uart_busy),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       ovf_clr;
    logic [3:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t       vec [13];
  int         total = 0;
  int         passed = 0;
  logic [7:0] sent [$];
  int         busy_cnt = 0;
  bit         model_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: sample just after the edge, record sends, run the busy model.
  task automatic step();
    @(posedge clk);
    #1;
    if (tx_send === 1'b1) sent.push_back(tx_data);
    if (model_en) begin
      if (tx_send === 1'b1) busy_cnt = 10;
      else if (busy_cnt > 0) busy_cnt--;
      uart_busy = (busy_cnt > 0);
    end
  endtask

  task automatic do_reset(input logic busy_during);
    model_en  = 1'b0;
    wr_en     = 1'b0;
    ovf_clr   = 1'b0;
    uart_busy = busy_during;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty_full_idle", {29'd0, empty, full, idle}, {29'd0, 3'b101});
    check("rst_send_ovf", {30'd0, tx_send, overflow}, 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    sent.delete();
  endtask

  initial begin
    // Occupancy/overflow table, UART held busy so nothing is popped.
    vec[0]  = '{1'b1, 8'hA0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 8'hA1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 8'hA2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 8'hA3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 8'hA4, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 8'hA5, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 8'hA6, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 8'hA7, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 8'hA8, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b1, 8'hA9, 1'b1, 4'd8, 1'b1, 1'b0, 1'b1};
    vec[11] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};

    do_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      wr_en   = vec[i].wr_en;
      wr_data = vec[i].data;
      ovf_clr = vec[i].ovf_clr;
      step();
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vec[i].exp_count));
      check($sformatf("vec%0d_flags", i), {29'd0, full, empty, overflow},
            {29'd0, vec[i].exp_full, vec[i].exp_empty, vec[i].exp_ovf});
      check($sformatf("vec%0d_send", i), 32'(tx_send), 32'd0);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    // Drain: exactly A0..A7 go out, dropped writes never appear.
    busy_cnt = 0; uart_busy = 1'b0; model_en = 1'b1;
    begin
      int n = 0;
      while (!(idle && sent.size() >= 8) && n < 400) begin step(); n++; end
      check("drain_timeout", 32'(n < 400), 32'd1);
      repeat (10) step();
      check("drain_nsent", 32'(sent.size()), 32'd8);
      for (int i = 0; i < 8 && i < sent.size(); i++)
        check($sformatf("drain_byte%0d", i), 32'(sent[i]), 32'hA0 + 32'(i));
    end

    // Single byte latency: push in N, strobe in N+2 only.
    do_reset(1'b0);
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    check("single_n1_send", 32'(tx_send), 32'd0);
    step();
    check("single_n2_send", 32'(tx_send), 32'd1);
    check("single_n2_data", 32'(tx_data), 32'h41);
    step();
    check("single_n3_send", 32'(tx_send), 32'd0);
    uart_busy = 1'b1;
    step();
    check("single_busy_idle", 32'(idle), 32'd0);
    uart_busy = 1'b0;
    step();
    check("single_done_idle", 32'(idle), 32'd1);
    check("single_hold_data", 32'(tx_data), 32'h41);

    // Busy-rise timeout, then the next queued byte pops right away.
    do_reset(1'b0);
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_data = 8'h66;
    check("to_n1_send", 32'(tx_send), 32'd0);
    step();
    wr_en = 1'b0;
    check("to_n2_send", 32'(tx_send), 32'd1);
    check("to_n2_data", 32'(tx_data), 32'h55);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("to_gap%0d_send", k), 32'(tx_send), 32'd0);
    end
    check("to_n7_idle", 32'(idle), 32'd0);
    check("to_n7_count", 32'(count), 32'd1);
    step();
    check("to_n8_send", 32'(tx_send), 32'd1);
    check("to_n8_data", 32'(tx_data), 32'h66);
    repeat (5) step();
    check("to_n13_idle", 32'(idle), 32'd1);

    // Ordering with a busy UART model; FIFO fills before the first pop.
    do_reset(1'b1);
    busy_cnt = 10; model_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("ord_full", 32'(full), 32'd1);
    begin
      int n = 0;
      while (!(idle && sent.size() >= 8) && n < 400) begin step(); n++; end
      check("ord_timeout", 32'(n < 400), 32'd1);
      check("ord_nsent", 32'(sent.size()), 32'd8);
      for (int i = 0; i < 8 && i < sent.size(); i++)
        check($sformatf("ord_byte%0d", i), 32'(sent[i]), 32'(i + 1));
    end

    // Reset while in WAIT_FALL with three bytes still queued.
    do_reset(1'b0);
    busy_cnt = 0; model_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      step();
    end
    wr_en = 1'b0;
    check("mid_count", 32'(count), 32'd3);
    check("mid_busy_idle", {30'd0, uart_busy, idle}, 32'b10);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_flags", {29'd0, empty, full, idle}, {29'd0, 3'b101});
    check("mid_rst_send_data", {23'd0, tx_send, tx_data}, 32'd0);
    model_en = 1'b0; uart_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step();
    check("mid_no_resend", 32'(sent.size()), 32'd1);
    check("mid_after_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
